alu_seq_core: RTL and testbench

ALU_SEQ_CORE -- requirements
Module: alu_seq_core

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_core_if.sv | 29 ++
 rtl/alu_mul_iter.sv | 64 ++++++
 rtl/alu_seq_core.sv | 127 ++++++++++++
 tb/tb_alu_seq_core.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU core: opcode and FSM state encodings.
package alu_pkg;

  localparam int OP_W    = 3;
  localparam int STATE_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_core_if.sv
// Request/response bundle of the sequential ALU core.
// Request transfers when in_valid && in_ready at a rising edge; response transfers
// when out_valid && out_ready; a response holds its value until it transfers.
interface alu_seq_core_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               flag_z;
  logic               flag_c;
  logic               flag_v;
  logic               busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_c, flag_v, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flag_z, flag_c, flag_v, busy
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: the start edge consumes bit 0 of b,
// each following cycle consumes one more bit; done flags the last iteration cycle.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{WIDTH{1'b0}}, a} << 1;
      mplier_d = b >> 1;
      cnt_d    = CW'(WIDTH - 1);
      run_d    = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  assign done    = run_q && (cnt_q == '0);
  assign product = acc_q;
endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative MUL, one
// operation in flight, response held until the consumer takes it.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_core_if.slave  bus,
  output state_e         dbg_state
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  op_e                op_q, op_d;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d  = bus.a;
          b_d  = bus.b;
          op_d = op_e'(bus.op);
          if (op_e'(bus.op) == OP_MUL) begin
            state_d   = ST_EXEC;
            mul_start = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_EXEC: if (mul_done) state_d = ST_DONE;
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Operands are registered, so the result is a stable function of them while in DONE.
  logic [SHW-1:0]     sh_amt;
  logic [WIDTH:0]     add_ext, sub_ext;
  logic [2*WIDTH-1:0] shl_ext, shr_ext, alu_res;
  logic               alu_c, alu_v;

  assign sh_amt  = b_q[SHW-1:0];
  assign add_ext = {1'b0, a_q} + {1'b0, b_q};
  assign sub_ext = {1'b0, a_q} - {1'b0, b_q};
  // The last bit shifted out lands just past the kept half; amount 0 leaves it clear.
  assign shl_ext = {{WIDTH{1'b0}}, a_q} << sh_amt;
  assign shr_ext = {a_q, {WIDTH{1'b0}}} >> sh_amt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = {{WIDTH{1'b0}}, add_ext[WIDTH-1:0]};
        alu_c   = add_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = {{WIDTH{1'b0}}, sub_ext[WIDTH-1:0]};
        alu_c   = sub_ext[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:  alu_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR: alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_SHL: begin
        alu_res = {{WIDTH{1'b0}}, shl_ext[WIDTH-1:0]};
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = {{WIDTH{1'b0}}, shr_ext[2*WIDTH-1:WIDTH]};
        alu_c   = shr_ext[WIDTH-1];
      end
      OP_MUL: begin
        alu_res = mul_product;
        alu_v   = |mul_product[2*WIDTH-1:WIDTH];
      end
      default: alu_res = '0;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.result    = bus.out_valid ? alu_res : '0;
  assign bus.flag_z    = bus.out_valid && (alu_res == '0);
  assign bus.flag_c    = bus.out_valid && alu_c;
  assign bus.flag_v    = bus.out_valid && alu_v;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed bench for alu_seq_core (WIDTH=8) with an arithmetic reference model.
module tb_alu_seq_core;
  import alu_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;

  alu_seq_core_if #(.WIDTH(8)) bus ();

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {result[15:0], z, c, v} from plain integer arithmetic.
  function automatic logic [18:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    int ua, ub, sa, sb, r, sh;
    logic z, c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sh = ub % 8;
    r  = 0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin
        r = ua + ub;
        c = (r > 255);
        v = (sa + sb > 127) || (sa + sb < -128);
        r = r % 256;
      end
      3'd1: begin
        r = (ua - ub + 256) % 256;
        c = (ua < ub);
        v = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin
        r = (ua << sh) % 256;
        c = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1);
      end
      3'd6: begin
        r = ua >> sh;
        c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1);
      end
      default: begin
        r = ua * ub;
        v = (r > 255);
      end
    endcase
    z = (r == 0);
    return {16'(r), z, c, v};
  endfunction

  // Compare process: every cycle, a valid response must match the head of the
  // expected queue and an idle response must read as all zeros.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0)
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      else
        chk("resp", 32'({bus.result, bus.flag_z, bus.flag_c, bus.flag_v}), 32'(exp_q[0]));
    end else begin
      chk("idle_zero", 32'({bus.result, bus.flag_z, bus.flag_c, bus.flag_v}), 32'd0);
    end
  end

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && exp_q.size() != 0)
      void'(exp_q.pop_front());
  end

  task automatic drive_junk();
    bus.in_valid = 1'b1;
    bus.a        = 8'($urandom_range(0, 255));
    bus.b        = 8'($urandom_range(0, 255));
    bus.op       = 3'($urandom_range(0, 7));
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       input int hold);
    int          lat;
    int          exp_lat;
    logic [18:0] held;
    exp_lat = (op == 3'd7) ? 9 : 1;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    exp_q.push_back(model(a, b, op));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      drive_junk();
      if (!bus.out_valid) chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
    end while (!bus.out_valid && lat < 40);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (bus.out_valid) begin
      held = {bus.result, bus.flag_z, bus.flag_c, bus.flag_v};
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        drive_junk();
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        chk("hold_stable", 32'({bus.result, bus.flag_z, bus.flag_c, bus.flag_v}), 32'(held));
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Model pinned against hand-computed values.
    chk("pin_add_ff_01",  32'(model(8'hFF, 8'h01, 3'd0)), 32'({16'h0000, 3'b110}));
    chk("pin_sub_80_01",  32'(model(8'h80, 8'h01, 3'd1)), 32'({16'h007F, 3'b001}));
    chk("pin_sub_00_01",  32'(model(8'h00, 8'h01, 3'd1)), 32'({16'h00FF, 3'b010}));
    chk("pin_mul_ff_ff",  32'(model(8'hFF, 8'hFF, 3'd7)), 32'({16'hFE01, 3'b001}));
    chk("pin_mul_00_37",  32'(model(8'h00, 8'h37, 3'd7)), 32'({16'h0000, 3'b100}));
    chk("pin_shl_81_09",  32'(model(8'h81, 8'h09, 3'd5)), 32'({16'h0002, 3'b010}));
    chk("pin_shr_81_00",  32'(model(8'h81, 8'h00, 3'd6)), 32'({16'h0081, 3'b000}));

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

    do_op(8'hFF, 8'h01, 3'd0, 0);
    do_op(8'h7F, 8'h01, 3'd0, 0);
    do_op(8'h80, 8'h01, 3'd1, 0);
    do_op(8'h00, 8'h01, 3'd1, 0);
    do_op(8'hC3, 8'h5A, 3'd2, 0);
    do_op(8'hC3, 8'h5A, 3'd3, 0);
    do_op(8'hC3, 8'hC3, 3'd4, 0);
    do_op(8'h81, 8'h09, 3'd5, 0);
    do_op(8'h81, 8'h07, 3'd5, 0);
    do_op(8'h81, 8'h00, 3'd6, 0);
    do_op(8'hC1, 8'h07, 3'd6, 0);
    do_op(8'hFF, 8'hFF, 3'd7, 0);
    do_op(8'h00, 8'h37, 3'd7, 0);
    do_op(8'h0F, 8'h11, 3'd7, 2);
    do_op(8'h9C, 8'h2B, 3'd1, 5);
    do_op(8'hB7, 8'h6D, 3'd7, 5);

    // Reset during the third EXEC cycle of a multiply discards it.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'hFF;
    bus.b        = 8'hFF;
    bus.op       = 3'd7;
    exp_q.push_back(model(8'hFF, 8'hFF, 3'd7));
    repeat (3) begin
      @(negedge clk);
      drive_junk();
    end
    chk("exec_busy", 32'(bus.busy), 32'd1);
    chk("exec_state", 32'(dbg_state), 32'(ST_EXEC));
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_outputs", 32'({bus.result, bus.flag_z, bus.flag_c, bus.flag_v}), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (12) begin
      @(negedge clk);
      chk("no_stale_out_valid", 32'(bus.out_valid), 32'd0);
    end

    do_op(8'h12, 8'h34, 3'd0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
